// File: rtl/ows_link_seq_pkg.sv
// Shared types and default timing for the 1-Wire slave link sequencer.
// Timing constants are in microseconds; the sequencer scales them by its clock rate.
package ows_link_seq_pkg;

    typedef enum logic [3:0] {
        StWaitRst,
        StRstLow,
        StPresDly,
        StPresLow,
        StPresRel,
        StSlotIdle,
        StSlotRun,
        StSlotEnd,
        StHalt
    } ls_state_e;

    localparam int unsigned OWS_CLK_PER_US = 50;
    localparam int unsigned OWS_RSTL_US    = 480;
    localparam int unsigned OWS_PDH_US     = 30;
    localparam int unsigned OWS_PDL_US     = 120;
    localparam int unsigned OWS_SAMP_US    = 30;
    localparam int unsigned OWS_CNT_W      = 16;

    function automatic int unsigned us_to_cyc(input int unsigned us, input int unsigned clk_per_us);
        return us * clk_per_us;
    endfunction

endpackage

// File: rtl/ows_link_seq_if.sv
// Link-side signal bundle between the DQ pad / command FSM and the link sequencer.
// slave: the sequencer itself; master: whatever drives DQ and consumes the byte stream.
interface ows_link_seq_if;
    logic       dq_in;
    logic       dq_pull;
    logic       start_flag;
    logic       write_ctrl;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic       tx_busy;
    logic       stop_flg;
    logic       link_err;

    modport slave (
        input  dq_in, tx_byte, tx_load, stop_flg,
        output dq_pull, start_flag, write_ctrl, rx_byte, tx_busy, link_err
    );

    modport master (
        output dq_in, tx_byte, tx_load, stop_flg,
        input  dq_pull, start_flag, write_ctrl, rx_byte, tx_busy, link_err
    );
endinterface

// File: rtl/ows_dq_sync.sv
// Two-flop synchronizer for the asynchronous DQ pad plus fall/rise detection on the synced value.
// Resets to the idle-high bus level so no spurious edge follows reset.
module ows_dq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic dq_i,
    output logic dq_o,
    output logic fall_o,
    output logic rise_o
);

    // [0] first stage, [1] synced DQ, [2] previous synced DQ
    logic [2:0] sr_q, sr_d;

    always_comb begin
        sr_d = {sr_q[1:0], dq_i};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q <= 3'b111;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dq_o   = sr_q[1];
    assign fall_o = sr_q[2] & ~sr_q[1];
    assign rise_o = ~sr_q[2] & sr_q[1];

endmodule

// File: rtl/ows_link_seq.sv
// 1-Wire slave bit-level link sequencer: reset qualification, presence pulse, slot timing,
// LSB-first byte assembly and read-slot serialisation, halting on stop_flg until the next bus reset.
module ows_link_seq
    import ows_link_seq_pkg::*;
#(
    parameter int unsigned CLK_PER_US = OWS_CLK_PER_US,
    parameter int unsigned RSTL_US    = OWS_RSTL_US,
    parameter int unsigned PDH_US     = OWS_PDH_US,
    parameter int unsigned PDL_US     = OWS_PDL_US,
    parameter int unsigned SAMP_US    = OWS_SAMP_US,
    parameter int unsigned CNT_W      = OWS_CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    ows_link_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] RSTL_M1  = CNT_W'(us_to_cyc(RSTL_US, CLK_PER_US) - 1);
    // SLOT_END sees the low level one edge before RST_LOW would see the rise, hence one less.
    localparam logic [CNT_W-1:0] RSTL_M2  = CNT_W'(us_to_cyc(RSTL_US, CLK_PER_US) - 2);
    localparam logic [CNT_W-1:0] PDH_M1   = CNT_W'(us_to_cyc(PDH_US, CLK_PER_US) - 1);
    localparam logic [CNT_W-1:0] PDL_M1   = CNT_W'(us_to_cyc(PDL_US, CLK_PER_US) - 1);
    localparam logic [CNT_W-1:0] SAMP_CYC = CNT_W'(us_to_cyc(SAMP_US, CLK_PER_US));

    ls_state_e        state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       rx_sr_q, rx_sr_d;
    logic [7:0]       tx_sr_q, tx_sr_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             tx_busy_q, tx_busy_d;
    logic             link_err_q, link_err_d;
    logic             start_flag_q, start_flag_d;
    logic             write_ctrl_q, write_ctrl_d;
    logic             dq_s, fall, rise;
    logic             dq_pull;

    ows_dq_sync u_dq_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .dq_i   (bus.dq_in),
        .dq_o   (dq_s),
        .fall_o (fall),
        .rise_o (rise)
    );

    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StWaitRst;
            timer_q      <= '0;
            bit_cnt_q    <= '0;
            rx_sr_q      <= '0;
            tx_sr_q      <= '0;
            rx_byte_q    <= '0;
            tx_busy_q    <= 1'b0;
            link_err_q   <= 1'b0;
            start_flag_q <= 1'b0;
            write_ctrl_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_sr_q      <= rx_sr_d;
            tx_sr_q      <= tx_sr_d;
            rx_byte_q    <= rx_byte_d;
            tx_busy_q    <= tx_busy_d;
            link_err_q   <= link_err_d;
            start_flag_q <= start_flag_d;
            write_ctrl_q <= write_ctrl_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_cnt_d    = bit_cnt_q;
        rx_sr_d      = rx_sr_q;
        tx_sr_d      = tx_sr_q;
        rx_byte_d    = rx_byte_q;
        tx_busy_d    = tx_busy_q;
        link_err_d   = link_err_q;
        start_flag_d = 1'b0;
        write_ctrl_d = 1'b0;

        case (state_q)
            StWaitRst, StHalt: begin
                if (fall) begin
                    state_d    = StRstLow;
                    timer_d    = '0;
                    link_err_d = 1'b0;
                end
            end
            StRstLow: begin
                timer_d = timer_inc;
                if (rise) begin
                    timer_d = '0;
                    state_d = (timer_q >= RSTL_M1) ? StPresDly : StWaitRst;
                end
            end
            StPresDly: begin
                if (!dq_s) begin
                    timer_d = '0;
                end else if (timer_q == PDH_M1) begin
                    state_d = StPresLow;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            StPresLow: begin
                if (timer_q == PDL_M1) begin
                    state_d = StPresRel;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            StPresRel: begin
                if (dq_s) begin
                    state_d      = StSlotIdle;
                    start_flag_d = 1'b1;
                    bit_cnt_d    = '0;
                    tx_busy_d    = 1'b0;
                end
            end
            StSlotIdle: begin
                if (bit_cnt_q == 3'd0 && bus.tx_load) begin
                    tx_sr_d   = bus.tx_byte;
                    tx_busy_d = 1'b1;
                end
                if (fall) begin
                    state_d = StSlotRun;
                    timer_d = '0;
                end
            end
            StSlotRun: begin
                timer_d = timer_inc;
                if (timer_q == SAMP_CYC) begin
                    state_d   = StSlotEnd;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (tx_busy_q) begin
                        tx_sr_d = tx_sr_q >> 1;
                        if (bit_cnt_q == 3'd7) begin
                            tx_busy_d = 1'b0;
                        end
                    end else begin
                        rx_sr_d = {dq_s, rx_sr_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            rx_byte_d    = {dq_s, rx_sr_q[7:1]};
                            write_ctrl_d = 1'b1;
                        end
                    end
                end
            end
            StSlotEnd: begin
                timer_d = timer_inc;
                // Level, not edge: a short write-1 low has already ended before the sample point.
                if (dq_s) begin
                    state_d = StSlotIdle;
                end else if (timer_q >= RSTL_M2) begin
                    state_d    = StRstLow;
                    link_err_d = 1'b1;
                    bit_cnt_d  = '0;
                    tx_busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StWaitRst;
            end
        endcase

        if (bus.stop_flg && (state_q == StSlotIdle || state_q == StSlotRun ||
                             state_q == StSlotEnd)) begin
            state_d      = StHalt;
            bit_cnt_d    = '0;
            tx_busy_d    = 1'b0;
            rx_byte_d    = rx_byte_q;
            write_ctrl_d = 1'b0;
            link_err_d   = link_err_q;
        end
    end

    always_comb begin
        dq_pull = 1'b0;
        case (state_q)
            StPresLow: dq_pull = 1'b1;
            StSlotRun: dq_pull = tx_busy_q & ~tx_sr_q[0] & (timer_q < SAMP_CYC);
            default:   dq_pull = 1'b0;
        endcase
    end

    assign bus.dq_pull    = dq_pull;
    assign bus.start_flag = start_flag_q;
    assign bus.write_ctrl = write_ctrl_q;
    assign bus.rx_byte    = rx_byte_q;
    assign bus.tx_busy    = tx_busy_q;
    assign bus.link_err   = link_err_q;

endmodule
